// File: rtl/vigna_bus_pkg.sv
// rtl/vigna_bus_pkg.sv - shared types and constants for the vigna bus arbiter
// Purpose: arbiter state encoding and port identifiers used by the top level
//          and the winner-select sub-module.
// Ports:   none (package).
package vigna_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/vigna_arb_pick.sv
// rtl/vigna_arb_pick.sv - combinational winner select for the vigna bus arbiter
// Purpose: decides whether any request is pending and which port wins.
// Ports:   i_valid, d_valid - request lines from the core ports
//          last             - port most recently granted (PORT_I / PORT_D)
//          grant            - at least one request pending
//          port             - winning port id (PORT_I / PORT_D)
import vigna_bus_pkg::*;

module vigna_arb_pick #(
  parameter int RR_MODE = 0
) (
  input  logic i_valid,
  input  logic d_valid,
  input  logic last,
  output logic grant,
  output logic port
);

  always_comb begin
    grant = i_valid | d_valid;
    port  = PORT_D;
    if (i_valid && !d_valid) begin
      port = PORT_I;
    end else if (i_valid && d_valid && (RR_MODE != 0)) begin
      // Round-robin: on a tie the port not served last wins.
      port = (last == PORT_D) ? PORT_I : PORT_D;
    end
  end

endmodule

// File: rtl/vigna_bus_arbiter.sv
// rtl/vigna_bus_arbiter.sv - two-to-one instruction/data bus arbiter with timeout
// Purpose: shares one memory port between the core's instruction and data
//          ports, registering the granted request and optionally aborting a
//          transaction whose slave never answers.
// Ports:   clk, resetn                     - clock, async active-low reset
//          i_valid/i_ready/i_addr/i_rdata/i_wdata/i_wstrb - instruction port
//          d_valid/d_ready/d_addr/d_rdata/d_wdata/d_wstrb - data port
//          m_valid/m_ready/m_addr/m_rdata/m_wdata/m_wstrb - shared memory port
//          bus_err                          - one-cycle pulse after a timeout abort
import vigna_bus_pkg::*;

module vigna_bus_arbiter #(
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,

  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  output logic [31:0] d_rdata,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,

  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  input  logic [31:0] m_rdata,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,

  output logic        bus_err
);

  // Counter value seen in the TIMEOUT-th cycle of a grant.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] cnt_q, cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;
  logic        bus_err_q, bus_err_d;

  logic        pick_grant;
  logic        pick_port;
  logic        in_grant;
  logic        timeout_hit;
  logic        done;
  logic [31:0] resp_rdata;

  vigna_arb_pick #(
    .RR_MODE (RR_MODE)
  ) u_pick (
    .i_valid (i_valid),
    .d_valid (d_valid),
    .last    (last_q),
    .grant   (pick_grant),
    .port    (pick_port)
  );

  assign in_grant    = (state_q != IDLE);
  assign timeout_hit = (TIMEOUT != 0) && in_grant && (cnt_q == TO_LAST) && !m_ready;
  assign done        = in_grant && (m_ready || timeout_hit);
  // An aborted transaction returns zero rather than whatever the bus floats.
  assign resp_rdata  = timeout_hit ? 32'h0 : m_rdata;

  assign i_ready = (state_q == GRANT_I) && (m_ready || timeout_hit);
  assign d_ready = (state_q == GRANT_D) && (m_ready || timeout_hit);
  assign i_rdata = (state_q == GRANT_I) ? resp_rdata : 32'h0;
  assign d_rdata = (state_q == GRANT_D) ? resp_rdata : 32'h0;

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign bus_err = bus_err_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    bus_err_d = timeout_hit;

    unique case (state_q)
      IDLE: begin
        // m_ready is ignored here: nothing is outstanding.
        if (pick_grant) begin
          m_valid_d = 1'b1;
          cnt_d     = 32'h0;
          if (pick_port == PORT_D) begin
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
            state_d   = GRANT_D;
          end else begin
            m_addr_d  = i_addr;
            m_wdata_d = i_wdata;
            m_wstrb_d = i_wstrb;
            state_d   = GRANT_I;
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (!m_ready) begin
          cnt_d = cnt_q + 32'h1;
        end
        // Requester valid is not consulted: a granted transaction always
        // runs to completion on the memory side.
        if (done) begin
          m_valid_d = 1'b0;
          last_d    = (state_q == GRANT_D) ? PORT_D : PORT_I;
          state_d   = IDLE;
        end
      end
      default: begin
        m_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      last_q    <= PORT_I;
      cnt_q     <= 32'h0;
      m_valid_q <= 1'b0;
      m_addr_q  <= 32'h0;
      m_wdata_q <= 32'h0;
      m_wstrb_q <= 4'h0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_vigna_bus_arbiter.sv
// tb/tb_vigna_bus_arbiter.sv - directed self-checking bench for vigna_bus_arbiter
module tb_vigna_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [3:0]  i_wstrb;
  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        m_ready;
  logic [31:0] m_rdata;

  // u_a: fixed priority, TIMEOUT=8
  logic        a_i_ready, a_d_ready, a_m_valid, a_bus_err;
  logic [31:0] a_i_rdata, a_d_rdata, a_m_addr, a_m_wdata;
  logic [3:0]  a_m_wstrb;
  // u_b: round-robin, no timeout
  logic        b_i_ready, b_d_ready, b_m_valid, b_bus_err;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_wstrb;

  int tests;
  int fails;

  vigna_bus_arbiter #(.RR_MODE(0), .TIMEOUT(8)) u_a (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(a_i_ready), .i_addr(i_addr), .i_rdata(a_i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(a_d_ready), .d_addr(d_addr), .d_rdata(a_d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(a_m_valid), .m_ready(m_ready), .m_addr(a_m_addr), .m_rdata(m_rdata),
    .m_wdata(a_m_wdata), .m_wstrb(a_m_wstrb),
    .bus_err(a_bus_err)
  );

  vigna_bus_arbiter #(.RR_MODE(1), .TIMEOUT(0)) u_b (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(b_i_ready), .i_addr(i_addr), .i_rdata(b_i_rdata),
    .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .d_valid(d_valid), .d_ready(b_d_ready), .d_addr(d_addr), .d_rdata(b_d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .m_valid(b_m_valid), .m_ready(m_ready), .m_addr(b_m_addr), .m_rdata(m_rdata),
    .m_wdata(b_m_wdata), .m_wstrb(b_m_wstrb),
    .bus_err(b_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 1'b0; i_addr = 32'h0; i_wdata = 32'h0; i_wstrb = 4'h0;
    d_valid = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    m_ready = 1'b0; m_rdata = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    #3;
    tests++;
    if ({a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb, a_bus_err} !== 70'h0) begin
      fails++;
      $display("FAIL reset_m_regs: got valid=%b addr=%h wdata=%h wstrb=%h err=%b, expected all 0",
               a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb, a_bus_err);
    end
    m_ready = 1'b1;
    m_rdata = 32'h1234_5678;
    #1;
    tests++;
    if ({a_i_ready, a_d_ready, a_i_rdata, a_d_rdata} !== 66'h0) begin
      fails++;
      $display("FAIL reset_resp: got i_ready=%b d_ready=%b i_rdata=%h d_rdata=%h, expected 0",
               a_i_ready, a_d_ready, a_i_rdata, a_d_rdata);
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    i_valid = 1'b1;
    i_addr  = 32'h100;
    tick();
    tests++;
    if ({a_m_valid, a_m_addr, a_m_wstrb} !== {1'b1, 32'h100, 4'h0}) begin
      fails++;
      $display("FAIL fetch_request: got valid=%b addr=%h wstrb=%h, expected 1/00000100/0",
               a_m_valid, a_m_addr, a_m_wstrb);
    end
    for (int c = 1; c <= 2; c++) begin
      tests++;
      if (a_i_ready !== 1'b0) begin
        fails++;
        $display("FAIL fetch_wait_c%0d: got i_ready=%b, expected 0", c, a_i_ready);
      end
      if (c == 1) tick();
    end
    tick();
    m_ready = 1'b1;
    m_rdata = 32'h0000_0013;
    #1;
    tests++;
    if ({a_i_ready, a_i_rdata, a_d_ready} !== {1'b1, 32'h13, 1'b0}) begin
      fails++;
      $display("FAIL fetch_response: got i_ready=%b i_rdata=%h d_ready=%b, expected 1/00000013/0",
               a_i_ready, a_i_rdata, a_d_ready);
    end
    i_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    #1;
    tests++;
    if ({a_m_valid, a_i_ready, a_d_ready} !== 3'b000) begin
      fails++;
      $display("FAIL fetch_done: got m_valid=%b i_ready=%b d_ready=%b, expected 000",
               a_m_valid, a_i_ready, a_d_ready);
    end
  endtask

  task automatic test_fixed_tie();
    do_reset();
    i_valid = 1'b1; i_addr = 32'h104;
    d_valid = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    tick();
    tests++;
    if ({a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb} !== {1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF}) begin
      fails++;
      $display("FAIL tie_d_first: got valid=%b addr=%h wdata=%h wstrb=%h, expected 1/00002000/deadbeef/f",
               a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb);
    end
    m_ready = 1'b1;
    #1;
    tests++;
    if ({a_d_ready, a_i_ready} !== 2'b10) begin
      fails++;
      $display("FAIL tie_d_ready: got d_ready=%b i_ready=%b, expected 1/0", a_d_ready, a_i_ready);
    end
    d_valid = 1'b0;
    tick();
    m_ready = 1'b0;
    #1;
    tests++;
    if (a_m_valid !== 1'b0) begin
      fails++;
      $display("FAIL tie_idle_gap: got m_valid=%b, expected 0", a_m_valid);
    end
    tick();
    tests++;
    if ({a_m_valid, a_m_addr, a_m_wstrb} !== {1'b1, 32'h104, 4'h0}) begin
      fails++;
      $display("FAIL tie_i_second: got valid=%b addr=%h wstrb=%h, expected 1/00000104/0",
               a_m_valid, a_m_addr, a_m_wstrb);
    end
    m_ready = 1'b1;
    #1;
    tests++;
    if ({a_i_ready, a_d_ready} !== 2'b10) begin
      fails++;
      $display("FAIL tie_i_ready: got i_ready=%b d_ready=%b, expected 1/0", a_i_ready, a_d_ready);
    end
    i_valid = 1'b0;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [5:0]  exp_d;
    logic [31:0] exp_addr;
    exp_d = 6'b010101;  // bit k set: transaction k goes to D (D,I,D,I,D,I)
    do_reset();
    i_valid = 1'b1; i_addr = 32'h1000;
    d_valid = 1'b1; d_addr = 32'h2000;
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp_addr = exp_d[k] ? 32'h2000 : 32'h1000;
      tests++;
      if ({b_m_valid, b_d_ready, b_i_ready, b_m_addr} !== {1'b1, exp_d[k], ~exp_d[k], exp_addr}) begin
        fails++;
        $display("FAIL rr_order_%0d: got valid=%b d_ready=%b i_ready=%b addr=%h, expected 1/%b/%b/%h",
                 k, b_m_valid, b_d_ready, b_i_ready, b_m_addr, exp_d[k], ~exp_d[k], exp_addr);
      end
      tick();
      tests++;
      if ({b_m_valid, b_d_ready, b_i_ready} !== 3'b000) begin
        fails++;
        $display("FAIL rr_idle_%0d: got valid=%b d_ready=%b i_ready=%b, expected 000",
                 k, b_m_valid, b_d_ready, b_i_ready);
      end
    end
    clear_inputs();
  endtask

  task automatic test_byte_store();
    do_reset();
    d_valid = 1'b1; d_addr = 32'h3; d_wdata = 32'h0000_00A5; d_wstrb = 4'h1;
    tick();
    // Upstream changes after the grant must not reach the memory port.
    d_addr = 32'hFFFF_FFF0; d_wdata = 32'h1111_1111; d_wstrb = 4'hE;
    for (int c = 1; c <= 5; c++) begin
      tests++;
      if ({a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb, a_d_ready} !==
          {1'b1, 32'h3, 32'h0000_00A5, 4'h1, 1'b0}) begin
        fails++;
        $display("FAIL store_stall_c%0d: got valid=%b addr=%h wdata=%h wstrb=%h d_ready=%b, expected 1/00000003/000000a5/1/0",
                 c, a_m_valid, a_m_addr, a_m_wdata, a_m_wstrb, a_d_ready);
      end
      tick();
    end
    m_ready = 1'b1;
    #1;
    tests++;
    if ({a_d_ready, a_m_addr, a_m_wstrb} !== {1'b1, 32'h3, 4'h1}) begin
      fails++;
      $display("FAIL store_done: got d_ready=%b addr=%h wstrb=%h, expected 1/00000003/1",
               a_d_ready, a_m_addr, a_m_wstrb);
    end
    d_valid = 1'b0;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    d_valid = 1'b1; d_addr = 32'h40;
    m_rdata = 32'hAAAA_5555;
    tick();
    for (int c = 1; c <= 7; c++) begin
      tests++;
      if ({a_m_valid, a_d_ready, a_bus_err} !== 3'b100) begin
        fails++;
        $display("FAIL timeout_wait_c%0d: got valid=%b d_ready=%b bus_err=%b, expected 1/0/0",
                 c, a_m_valid, a_d_ready, a_bus_err);
      end
      tick();
    end
    tests++;
    if ({a_d_ready, a_d_rdata, a_bus_err} !== {1'b1, 32'h0, 1'b0}) begin
      fails++;
      $display("FAIL timeout_hit: got d_ready=%b d_rdata=%h bus_err=%b, expected 1/00000000/0",
               a_d_ready, a_d_rdata, a_bus_err);
    end
    d_valid = 1'b0;
    tick();
    tests++;
    if ({a_bus_err, a_m_valid, a_d_ready} !== 3'b100) begin
      fails++;
      $display("FAIL timeout_err: got bus_err=%b m_valid=%b d_ready=%b, expected 1/0/0",
               a_bus_err, a_m_valid, a_d_ready);
    end
    tick();
    tests++;
    if ({a_bus_err, a_m_valid} !== 2'b00) begin
      fails++;
      $display("FAIL timeout_err_clear: got bus_err=%b m_valid=%b, expected 0/0", a_bus_err, a_m_valid);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    i_valid = 1'b1; i_addr = 32'h200;
    tick();
    tests++;
    if ({a_m_valid, a_m_addr} !== {1'b1, 32'h200}) begin
      fails++;
      $display("FAIL rst_pre_grant: got valid=%b addr=%h, expected 1/00000200", a_m_valid, a_m_addr);
    end
    #2;
    resetn = 1'b0;
    m_ready = 1'b1;
    #1;
    tests++;
    if ({a_m_valid, a_i_ready} !== 2'b00) begin
      fails++;
      $display("FAIL rst_async_drop: got m_valid=%b i_ready=%b, expected 0/0", a_m_valid, a_i_ready);
    end
    m_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    tests++;
    if ({a_m_valid, a_m_addr} !== {1'b1, 32'h200}) begin
      fails++;
      $display("FAIL rst_refetch_req: got valid=%b addr=%h, expected 1/00000200", a_m_valid, a_m_addr);
    end
    m_ready = 1'b1;
    m_rdata = 32'h0000_0077;
    #1;
    tests++;
    if ({a_i_ready, a_i_rdata} !== {1'b1, 32'h77}) begin
      fails++;
      $display("FAIL rst_refetch_resp: got i_ready=%b i_rdata=%h, expected 1/00000077", a_i_ready, a_i_rdata);
    end
    i_valid = 1'b0;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_fixed_tie();
    test_round_robin();
    test_byte_store();
    test_timeout();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
